// File: rtl/rv32i_fetch_decode_if.sv
// Fetch/decode bus: program-load port, fetch enable and the decoded
// instruction handshake toward the execute stage.
interface rv32i_fetch_decode_if #(
  parameter int AW = 5
) ();
  logic          en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          valid;
  logic          ready;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [9:0]    cls;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          illegal;
  logic          halted;

  // Environment side: loads the program, enables fetch, consumes instructions.
  modport master (
    output en, wr_en, wr_addr, wr_data, ready,
    input  valid, pc, instr, cls, rd, rs1, rs2, funct3, funct7, imm, illegal, halted
  );

  // Fetch/decode stage side.
  modport slave (
    input  en, wr_en, wr_addr, wr_data, ready,
    output valid, pc, instr, cls, rd, rs1, rs2, funct3, funct7, imm, illegal, halted
  );
endinterface

// File: rtl/rv32i_fetch_decode.sv
// RV32I fetch/decode stage: on-chip program memory with synchronous read,
// registered fetch, combinational field/immediate decode, valid/ready output
// handshake and halt on EBREAK.
module rv32i_fetch_decode #(
  parameter int          DEPTH          = 32,
  parameter int          AW             = $clog2(DEPTH),
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  rv32i_fetch_decode_if.slave bus
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_VALID,
    S_HALT
  } state_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t               state_q, state_d;
  logic [31:0]          mem [DEPTH];
  logic [31:0]          pc_q;
  logic [31:0]          instr_p1;
  logic                 vld_p1;
  logic                 xfer;
  logic                 halt_take;
  logic [AW-1:0]        widx;
  logic [AW-1:0]        widx_next;
  logic [31:0]          pc_next;
  logic [6:0]           opcode;
  logic [9:0]           cls;
  logic signed [31:0]   imm_s;

  assign widx      = pc_q[AW+1:2];
  assign widx_next = widx + 1'b1;
  // Word index wraps naturally, so the PC returns to 0 after the last word.
  assign pc_next   = {{(30-AW){1'b0}}, widx_next, 2'b00};
  assign vld_p1    = (state_q == S_VALID);
  assign xfer      = vld_p1 && bus.ready;
  assign halt_take = HALT_ON_EBREAK && (instr_p1 == EBREAK);

  // Program-load write port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  // Fetch stage: synchronous read captures the word at the PC (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1 <= '0;
    end else if (state_q == S_FETCH && bus.en) begin
      instr_p1 <= mem[widx];
    end
  end

  // State and PC registers; PC only moves on a non-halting transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (xfer && !halt_take) pc_q <= pc_next;
    end
  end

  // Next-state logic: FETCH -> VALID -> FETCH, or VALID -> HALT on EBREAK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (bus.en) state_d = S_VALID;
      S_VALID: if (bus.ready) state_d = halt_take ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Opcode classification; any unlisted opcode (incl. low bits != 2'b11) is illegal.
  always_comb begin
    opcode = instr_p1[6:0];
    cls    = '0;
    case (opcode)
      7'b0110011: cls[0] = 1'b1;
      7'b0010011: cls[1] = 1'b1;
      7'b0000011: cls[2] = 1'b1;
      7'b0100011: cls[3] = 1'b1;
      7'b1100011: cls[4] = 1'b1;
      7'b1101111: cls[5] = 1'b1;
      7'b1100111: cls[6] = 1'b1;
      7'b0110111: cls[7] = 1'b1;
      7'b0010111: cls[8] = 1'b1;
      7'b1110011: cls[9] = 1'b1;
      default:    cls    = '0;
    endcase
  end

  // Immediate assembly by instruction format; R-type and illegal give zero.
  always_comb begin
    imm_s = '0;
    if (cls[1] || cls[2] || cls[6] || cls[9]) begin
      imm_s = {{20{instr_p1[31]}}, instr_p1[31:20]};
    end else if (cls[3]) begin
      imm_s = {{20{instr_p1[31]}}, instr_p1[31:25], instr_p1[11:7]};
    end else if (cls[4]) begin
      imm_s = {{19{instr_p1[31]}}, instr_p1[31], instr_p1[7], instr_p1[30:25],
               instr_p1[11:8], 1'b0};
    end else if (cls[7] || cls[8]) begin
      imm_s = {instr_p1[31:12], 12'b0};
    end else if (cls[5]) begin
      imm_s = {{11{instr_p1[31]}}, instr_p1[31], instr_p1[19:12], instr_p1[20],
               instr_p1[30:21], 1'b0};
    end
  end

  assign bus.valid   = vld_p1;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.pc      = pc_q;
  assign bus.instr   = instr_p1;
  assign bus.cls     = cls;
  assign bus.illegal = (cls == '0);
  assign bus.rd      = instr_p1[11:7];
  assign bus.rs1     = instr_p1[19:15];
  assign bus.rs2     = instr_p1[24:20];
  assign bus.funct3  = instr_p1[14:12];
  assign bus.funct7  = instr_p1[31:25];
  assign bus.imm     = imm_s;

endmodule
